// File: rtl/tiny_rv_decode_q_if.sv
// rtl/tiny_rv_decode_q_if.sv - fetch/decode handshake bundle for the decode queue
interface tiny_rv_decode_q_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            i_flush;
    logic            i_fetch_valid;
    logic            o_fetch_ready;
    logic [XLEN-1:0] i_fetch_pc;
    logic [31:0]     i_fetch_inst;
    logic            o_dec_valid;
    logic            i_dec_ready;
    logic [XLEN-1:0] o_dec_pc;
    logic [31:0]     o_dec_inst;
    logic [XLEN-1:0] o_dec_imm;
    logic [6:0]      o_dec_opcode;
    logic [2:0]      o_dec_funct3;
    logic [6:0]      o_dec_funct7;
    logic [4:0]      o_dec_rs1;
    logic [4:0]      o_dec_rs2;
    logic [4:0]      o_dec_rd;
    logic            o_dec_illegal;
    logic [CW-1:0]   o_count;

    modport master (
        output i_flush, i_fetch_valid, i_fetch_pc, i_fetch_inst, i_dec_ready,
        input  o_fetch_ready, o_dec_valid, o_dec_pc, o_dec_inst, o_dec_imm,
               o_dec_opcode, o_dec_funct3, o_dec_funct7, o_dec_rs1, o_dec_rs2,
               o_dec_rd, o_dec_illegal, o_count
    );

    modport slave (
        input  i_flush, i_fetch_valid, i_fetch_pc, i_fetch_inst, i_dec_ready,
        output o_fetch_ready, o_dec_valid, o_dec_pc, o_dec_inst, o_dec_imm,
               o_dec_opcode, o_dec_funct3, o_dec_funct7, o_dec_rs1, o_dec_rs2,
               o_dec_rd, o_dec_illegal, o_count
    );
endinterface

// File: rtl/tiny_rv_decode_q.sv
// rtl/tiny_rv_decode_q.sv - RV base instruction pre-decoder with a small in-order queue
module tiny_rv_decode_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    tiny_rv_decode_q_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic               full, empty, fetch_ready, push, pop;
    logic               legal, no_rd;
    logic [6:0]         opc;
    logic signed [31:0] imm32;
    entry_t             new_e, head;

    // Decode happens on the way in so the queue holds ready-to-use fields.
    always_comb begin
        opc   = bus.i_fetch_inst[6:0];
        imm32 = '0;
        legal = 1'b1;
        no_rd = 1'b0;
        unique case (opc)
            7'b0110111, 7'b0010111:
                imm32 = {bus.i_fetch_inst[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{bus.i_fetch_inst[31]}}, bus.i_fetch_inst[31],
                         bus.i_fetch_inst[19:12], bus.i_fetch_inst[20],
                         bus.i_fetch_inst[30:21], 1'b0};
            7'b1100011: begin
                imm32 = {{19{bus.i_fetch_inst[31]}}, bus.i_fetch_inst[31],
                         bus.i_fetch_inst[7], bus.i_fetch_inst[30:25],
                         bus.i_fetch_inst[11:8], 1'b0};
                no_rd = 1'b1;
            end
            7'b0100011: begin
                imm32 = {{20{bus.i_fetch_inst[31]}}, bus.i_fetch_inst[31:25],
                         bus.i_fetch_inst[11:7]};
                no_rd = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                imm32 = {{20{bus.i_fetch_inst[31]}}, bus.i_fetch_inst[31:20]};
            7'b0110011, 7'b0001111:
                imm32 = '0;
            default:
                legal = 1'b0;
        endcase
        if (bus.i_fetch_inst[1:0] != 2'b11) begin
            legal = 1'b0;
        end
        new_e.pc   = bus.i_fetch_pc;
        new_e.inst = bus.i_fetch_inst;
        new_e.imm  = legal ? XLEN'(imm32) : '0;
        new_e.rd   = (legal && !no_rd) ? bus.i_fetch_inst[11:7] : 5'd0;
        new_e.ill  = !legal;
    end

    always_comb begin
        full        = (count_q == FULL_CNT);
        empty       = (count_q == '0);
        fetch_ready = !full && !i_reset;
        push        = bus.i_fetch_valid && fetch_ready;
        pop         = !empty && bus.i_dec_ready;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty queue masks every data output.
    always_ff @(posedge i_clk) begin
        if (push && !bus.i_flush) begin
            mem_q[wr_ptr_q] <= new_e;
        end
    end

    always_comb begin
        head = empty ? '0 : mem_q[rd_ptr_q];
    end

    assign bus.o_fetch_ready = fetch_ready;
    assign bus.o_dec_valid   = !empty;
    assign bus.o_count       = count_q;
    assign bus.o_dec_pc      = head.pc;
    assign bus.o_dec_inst    = head.inst;
    assign bus.o_dec_imm     = head.imm;
    assign bus.o_dec_opcode  = head.inst[6:0];
    assign bus.o_dec_funct3  = head.inst[14:12];
    assign bus.o_dec_funct7  = head.inst[31:25];
    assign bus.o_dec_rs1     = head.inst[19:15];
    assign bus.o_dec_rs2     = head.inst[24:20];
    assign bus.o_dec_rd      = head.rd;
    assign bus.o_dec_illegal = head.ill;
endmodule
